// File: rtl/led_beat_scanner.sv
// rtl/led_beat_scanner.sv - LED scan chain driver with per-beat blink and forward/reverse/ping-pong/hold stepping (optional ping-pong: LED_BEAT_PINGPONG_EN)
module led_beat_scanner #(
    parameter int N_LED  = 8,
    parameter int PERIOD = 2400,
    localparam int IW    = (N_LED > 1) ? $clog2(N_LED) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [N_LED-1:0] led_out,
    output logic [IW-1:0]    led_idx,
    output logic             beat_done
);

    localparam int CW = $clog2(PERIOD);
    localparam int Q  = PERIOD / 4;

    localparam logic [CW-1:0]    CNT_MAX = CW'(PERIOD - 1);
    localparam logic [CW-1:0]    Q1      = CW'(Q);
    localparam logic [CW-1:0]    Q2      = CW'(2 * Q);
    localparam logic [CW-1:0]    Q3      = CW'(3 * Q);
    localparam logic [IW-1:0]    IDX_MAX = IW'(N_LED - 1);
    localparam logic [N_LED-1:0] ONE     = N_LED'(1);

    logic [CW-1:0] cnt;
    logic          wrap;
    logic          on_phase;
    logic [IW-1:0] idx_fwd;
    logic [IW-1:0] idx_rev;
    logic [IW-1:0] idx_next;

`ifdef LED_BEAT_PINGPONG_EN
    logic dir;        // 1 = stepping up
    logic pp_active;  // last wrap was taken in ping-pong mode
    logic pp_up;
`endif

    assign wrap     = (cnt == CNT_MAX);
    assign on_phase = (cnt < Q1) || ((cnt >= Q2) && (cnt < Q3));

    // Next LED index for the upcoming wrap, selected by the mode sampled on that cycle
    always_comb begin
        idx_fwd  = (led_idx == IDX_MAX) ? '0 : led_idx + 1'b1;
        idx_rev  = (led_idx == '0) ? IDX_MAX : led_idx - 1'b1;
        idx_next = led_idx;
`ifdef LED_BEAT_PINGPONG_EN
        // Fresh entry into ping-pong starts upward unless already at the top end
        pp_up = pp_active ? dir : (led_idx != IDX_MAX);
        if (pp_up && (led_idx == IDX_MAX)) begin
            pp_up = 1'b0;
        end else if (!pp_up && (led_idx == '0)) begin
            pp_up = 1'b1;
        end
`endif
        case (mode)
            2'b00: idx_next = idx_fwd;
            2'b01: idx_next = idx_rev;
`ifdef LED_BEAT_PINGPONG_EN
            2'b10: idx_next = (N_LED == 1) ? led_idx :
                              (pp_up ? led_idx + 1'b1 : led_idx - 1'b1);
`else
            2'b10: idx_next = idx_fwd;
`endif
            default: idx_next = led_idx;
        endcase
    end

    // Phase counter, index stepping and registered LED/beat outputs; en low freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            led_idx   <= '0;
            led_out   <= '0;
            beat_done <= 1'b0;
`ifdef LED_BEAT_PINGPONG_EN
            dir       <= 1'b1;
            pp_active <= 1'b0;
`endif
        end else if (en) begin
            led_out   <= on_phase ? (ONE << led_idx) : '0;
            beat_done <= wrap;
            if (wrap) begin
                cnt     <= '0;
                led_idx <= idx_next;
`ifdef LED_BEAT_PINGPONG_EN
                if (mode == 2'b10) begin
                    dir <= pp_up;
                end
                pp_active <= (mode == 2'b10);
`endif
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            led_out   <= '0;
            beat_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_beat_scanner.sv
// tb/tb_led_beat_scanner.sv - self-checking bench for led_beat_scanner (N_LED=4 and N_LED=1, PERIOD=8)
module tb_led_beat_scanner;

    localparam int P = 8;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n, en;
    logic [1:0] mode;
    logic [3:0] led_out;
    logic [1:0] led_idx;
    logic       beat_done;

    logic       rst1_n, en1;
    logic [1:0] mode1;
    logic [0:0] led_out1;
    logic [0:0] led_idx1;
    logic       beat_done1;

    always #5 clk = ~clk;

    led_beat_scanner #(.N_LED(N), .PERIOD(P)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .led_out(led_out), .led_idx(led_idx), .beat_done(beat_done)
    );

    led_beat_scanner #(.N_LED(1), .PERIOD(P)) dut1 (
        .clk(clk), .rst_n(rst1_n), .en(en1), .mode(mode1),
        .led_out(led_out1), .led_idx(led_idx1), .beat_done(beat_done1)
    );

    typedef struct {
        logic [3:0] led;
        logic [1:0] idx;
        logic       bd;
    } exp_t;

    typedef struct {
        logic [1:0] mode_a;   // mode for the first half of the period
        logic [1:0] mode_b;   // mode for the second half, seen by the wrap
        int         idx_next;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit on_ph(input int c);
        int q;
        q = P / 4;
        return (c < q) || ((c >= 2 * q) && (c < 3 * q));
    endfunction

    function automatic void add(input logic [1:0] a, input logic [1:0] b, input int n);
        vec_t v;
        v.mode_a   = a;
        v.mode_b   = b;
        v.idx_next = n;
        vecs.push_back(v);
    endfunction

    task automatic step(input logic e, input logic [1:0] m, input logic [3:0] xl,
                        input logic [1:0] xi, input logic xb);
        exp_t x, y;
        en    = e;
        mode  = m;
        x.led = xl;
        x.idx = xi;
        x.bd  = xb;
        sb_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        y = sb_q.pop_front();
        check("led_out", led_out, y.led);
        check("led_idx", led_idx, y.idx);
        check("beat_done", beat_done, y.bd);
    endtask

    task automatic run_period(input logic [1:0] ma, input logic [1:0] mb, input int cur, input int nxt);
        for (int j = 1; j <= P; j++) begin
            step(1'b1, (j <= P / 2) ? ma : mb,
                 on_ph(j - 1) ? 4'(1 << cur) : 4'b0,
                 (j == P) ? 2'(nxt) : 2'(cur),
                 j == P);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'b00;
        sb_q.delete();
        repeat (3) @(negedge clk);
        check("rst_led_out", led_out, 0);
        check("rst_led_idx", led_idx, 0);
        check("rst_beat_done", beat_done, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int cur, t, u;
        rst1_n = 1'b0;
        en1    = 1'b0;
        mode1  = 2'b00;

        // Forward, reverse, return to 0
        add(2'b00, 2'b00, 1); add(2'b00, 2'b00, 2); add(2'b00, 2'b00, 3); add(2'b00, 2'b00, 0);
        add(2'b01, 2'b01, 3); add(2'b01, 2'b01, 2); add(2'b01, 2'b01, 1); add(2'b01, 2'b01, 0);
        add(2'b01, 2'b01, 3);
        add(2'b00, 2'b00, 0);
`ifdef LED_BEAT_PINGPONG_EN
        add(2'b10, 2'b10, 1); add(2'b10, 2'b10, 2); add(2'b10, 2'b10, 3); add(2'b10, 2'b10, 2);
        add(2'b10, 2'b10, 1); add(2'b10, 2'b10, 0); add(2'b10, 2'b10, 1);
        t = 1;
`else
        add(2'b10, 2'b10, 1); add(2'b10, 2'b10, 2); add(2'b10, 2'b10, 3); add(2'b10, 2'b10, 0);
        t = 0;
`endif
        // Hold, then mid-period mode changes that only count at the wrap
        u = (t + 1) % N;
        add(2'b11, 2'b11, t); add(2'b11, 2'b11, t);
        add(2'b11, 2'b00, u); add(2'b00, 2'b11, u);
        // Walk up to the top index, then enter ping-pong from there
        while (u != N - 1) begin
            u = (u + 1) % N;
            add(2'b00, 2'b00, u);
        end
`ifdef LED_BEAT_PINGPONG_EN
        add(2'b10, 2'b10, N - 2);
`else
        add(2'b10, 2'b10, 0);
`endif

        do_reset();
        check("rst_n1_led_out", led_out1, 0);
        check("rst_n1_beat_done", beat_done1, 0);

        cur = 0;
        foreach (vecs[i]) begin
            run_period(vecs[i].mode_a, vecs[i].mode_b, cur, vecs[i].idx_next);
            cur = vecs[i].idx_next;
        end

        // Enable gap at cnt=3
        for (int j = 0; j < 3; j++) step(1'b1, 2'b00, on_ph(j) ? 4'(1 << cur) : 4'b0, 2'(cur), 1'b0);
        check("cnt_before_gap", dut.cnt, 3);
        for (int k = 0; k < 5; k++) step(1'b0, 2'b00, 4'b0, 2'(cur), 1'b0);
        check("cnt_frozen", dut.cnt, 3);
        for (int j = 3; j < P; j++)
            step(1'b1, 2'b00, on_ph(j) ? 4'(1 << cur) : 4'b0,
                 (j == P - 1) ? 2'((cur + 1) % N) : 2'(cur), j == P - 1);

        // Reset mid-run at cnt=5, idx=2
        do_reset();
        run_period(2'b00, 2'b00, 0, 1);
        run_period(2'b00, 2'b00, 1, 2);
        for (int j = 0; j < 5; j++) step(1'b1, 2'b00, on_ph(j) ? 4'b0100 : 4'b0, 2'd2, 1'b0);
        check("pre_rst_led_out", led_out, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led_out", led_out, 0);
        check("async_rst_led_idx", led_idx, 0);
        check("async_rst_beat_done", beat_done, 0);
        check("async_rst_cnt", dut.cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_period(2'b00, 2'b00, 0, 1);

        // N_LED=1 in all modes
        @(negedge clk);
        rst1_n = 1'b1;
        en1    = 1'b1;
        for (int m = 0; m < 4; m++) begin
            for (int j = 1; j <= P; j++) begin
                mode1 = 2'(m);
                @(posedge clk);
                @(negedge clk);
                check("n1_led_out", led_out1, {31'b0, on_ph(j - 1)});
                check("n1_led_idx", led_idx1, 0);
                check("n1_beat_done", beat_done1, {31'b0, j == P});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
